// File: rtl/instr_mem_loader.sv
// Instruction-memory controller: loads a program from a byte stream while holding
// the CPU in reset, then serves the CPU's combinational instruction fetch.
module instr_mem_loader #(
    parameter int unsigned SIZE   = 16,
    parameter int unsigned ADDR_W = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              load_done,
    output logic              busy,
    output logic              cpu_rst,
    input  logic [31:0]       fetch_addr,
    output logic [31:0]       fetch_data
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    state_e            state_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [ADDR_W-1:0] last_q;
    logic [23:0]       asm_q;
    logic              done_q;
    logic [31:0]       mem_q [SIZE];

    logic [ADDR_W-1:0] last_d;
    logic [31:0]       word_d;
    logic              unused_fetch_hi;

    // Index of the final word to load: 0 or oversized lengths mean a full load.
    always_comb begin
        last_d = ADDR_W'(SIZE - 1);
        if (load_len != '0 && load_len <= (ADDR_W+1)'(SIZE)) begin
            last_d = ADDR_W'(load_len - (ADDR_W+1)'(1));
        end
    end

    assign word_d = {byte_data, asm_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            last_q  <= '0;
            asm_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < int'(SIZE); i++) begin
                mem_q[i] <= NOP;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_RUN: begin
                    if (load_start) begin
                        state_q <= S_LOAD;
                        cnt_q   <= '0;
                        waddr_q <= '0;
                        asm_q   <= '0;
                        last_q  <= last_d;
                    end else if (state_q == S_IDLE && run) begin
                        state_q <= S_RUN;
                    end
                end
                S_LOAD: begin
                    if (byte_valid) begin
                        if (cnt_q == 2'd3) begin
                            // Fourth byte completes the little-endian word.
                            mem_q[waddr_q] <= word_d;
                            waddr_q        <= waddr_q + ADDR_W'(1);
                            cnt_q          <= '0;
                            asm_q          <= '0;
                            if (waddr_q == last_q) begin
                                state_q <= S_RUN;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            case (cnt_q)
                                2'd0:    asm_q[7:0]   <= byte_data;
                                2'd1:    asm_q[15:8]  <= byte_data;
                                default: asm_q[23:16] <= byte_data;
                            endcase
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_ready = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD);
    assign cpu_rst    = (state_q != S_RUN);
    assign load_done  = done_q;

    // Fetch wraps modulo SIZE; upper address bits are intentionally ignored.
    assign fetch_data      = (state_q == S_RUN) ? mem_q[fetch_addr[ADDR_W-1:0]] : NOP;
    assign unused_fetch_hi = ^fetch_addr[31:ADDR_W];

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table-driven length vectors, directed
// corner sequences and randomized loads checked against a word-array model.
module tb_instr_mem_loader;

    localparam int unsigned SIZE = 16;
    localparam int unsigned AW   = 4;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic          clk;
    logic          rst;
    logic          run;
    logic          load_start;
    logic [AW:0]   load_len;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic          load_done;
    logic          busy;
    logic          cpu_rst;
    logic [31:0]   fetch_addr;
    logic [31:0]   fetch_data;

    instr_mem_loader #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .load_start (load_start),
        .load_len   (load_len),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .load_done  (load_done),
        .busy       (busy),
        .cpu_rst    (cpu_rst),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [SIZE];
    logic [7:0]  bq [$];

    typedef struct {
        logic [AW:0] len;
        int          exp_n;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_n(input int len);
        return (len == 0 || len > int'(SIZE)) ? int'(SIZE) : len;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(SIZE); i++) ref_mem[i] = NOP;
    endtask

    // Every word index, aliased through random upper address bits.
    task automatic check_mem(input string tag);
        for (int a = 0; a < int'(SIZE); a++) begin
            fetch_addr = 32'(a) + 32'(SIZE) * 32'($urandom_range(0, 1000));
            #1;
            chk(tag, fetch_data, ref_mem[a]);
        end
        fetch_addr = '0;
    endtask

    // Load n words (bytes from bq, random if empty); leaves the DUT in RUN.
    task automatic do_load(input int len, input int n, input bit with_run,
                           input int gapmax, input string tag);
        int gap;
        if (bq.size() == 0) begin
            for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom_range(0, 255)));
        end
        load_start = 1'b1;
        run        = with_run;
        load_len   = (AW+1)'(len);
        step();
        load_start = 1'b0;
        run        = 1'b0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " cpu_rst_entry"}, 32'(cpu_rst), 32'd1);
        chk({tag, " fetch_in_load"}, fetch_data, NOP);
        for (int i = 0; i < bq.size(); i++) begin
            gap = $urandom_range(0, gapmax);
            repeat (gap) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom_range(0, 255));
                step();
                chk({tag, " ready_gap"}, 32'(byte_ready), 32'd1);
                chk({tag, " cpu_rst_gap"}, 32'(cpu_rst), 32'd1);
            end
            byte_valid = 1'b1;
            byte_data  = bq[i];
            step();
            if (i < bq.size() - 1) begin
                chk({tag, " ready_mid"}, 32'(byte_ready), 32'd1);
                chk({tag, " done_early"}, 32'(load_done), 32'd0);
            end
        end
        byte_valid = 1'b0;
        chk({tag, " load_done"}, 32'(load_done), 32'd1);
        chk({tag, " cpu_rst_run"}, 32'(cpu_rst), 32'd0);
        chk({tag, " ready_end"}, 32'(byte_ready), 32'd0);
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
        for (int w = 0; w < n; w++) begin
            ref_mem[w] = {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
        end
        bq.delete();
        step();
        chk({tag, " done_pulse"}, 32'(load_done), 32'd0);
        check_mem({tag, " mem"});
        step();
    endtask

    initial begin
        tbl[0] = '{len: 5'd1,  exp_n: 1};
        tbl[1] = '{len: 5'd2,  exp_n: 2};
        tbl[2] = '{len: 5'd0,  exp_n: 16};
        tbl[3] = '{len: 5'd16, exp_n: 16};
        tbl[4] = '{len: 5'd17, exp_n: 16};
        tbl[5] = '{len: 5'd31, exp_n: 16};
        tbl[6] = '{len: 5'd5,  exp_n: 5};

        rst        = 1'b1;
        run        = 1'b0;
        load_start = 1'b0;
        load_len   = '0;
        byte_data  = '0;
        byte_valid = 1'b0;
        fetch_addr = 32'd7;
        model_reset();
        #3;
        chk("rst byte_ready", 32'(byte_ready), 32'd0);
        chk("rst load_done", 32'(load_done), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst fetch7", fetch_data, NOP);
        fetch_addr = 32'hffff_fff0;
        #1;
        chk("rst fetch_hi", fetch_data, NOP);
        step();
        rst = 1'b0;
        step();
        chk("idle cpu_rst", 32'(cpu_rst), 32'd1);
        chk("idle fetch", fetch_data, NOP);

        // 2-word load from IDLE with no gaps, known bytes.
        bq = '{8'h93, 8'h02, 8'h30, 8'h12, 8'h37, 8'h53, 8'h34, 8'h12};
        do_load(2, 2, 1'b0, 0, "two_word");
        fetch_addr = 32'd1; #1; chk("two_word w1", fetch_data, 32'h12345337);
        fetch_addr = 32'd0; #1; chk("two_word w0", fetch_data, 32'h12300293);
        fetch_addr = 32'd2; #1; chk("two_word w2", fetch_data, NOP);
        step();

        // Same program with random backpressure gaps, reloaded from RUN.
        bq = '{8'h93, 8'h02, 8'h30, 8'h12, 8'h37, 8'h53, 8'h34, 8'h12};
        do_load(2, 2, 1'b0, 3, "backpressure");

        // Full load, len=0 meaning SIZE.
        for (int i = 0; i < int'(SIZE); i++) begin
            logic [31:0] w;
            w = 32'h100 * 32'(i) + 32'h13;
            bq.push_back(w[7:0]); bq.push_back(w[15:8]);
            bq.push_back(w[23:16]); bq.push_back(w[31:24]);
        end
        do_load(0, 16, 1'b0, 1, "full");
        fetch_addr = 32'd17; #1; chk("full wrap17", fetch_data, 32'h00000113);
        step();

        // Single-word reload from RUN.
        bq = '{8'hef, 8'hbe, 8'had, 8'hde};
        do_load(1, 1, 1'b0, 0, "reload");
        fetch_addr = 32'd0; #1; chk("reload w0", fetch_data, 32'hdeadbeef);
        step();

        // Bytes and run are ignored in RUN.
        run        = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'haa;
        repeat (6) begin
            step();
            chk("run_ign ready", 32'(byte_ready), 32'd0);
        end
        run        = 1'b0;
        byte_valid = 1'b0;
        check_mem("run_ign mem");
        step();

        // Table of effective-length cases.
        for (int t = 0; t < 7; t++) begin
            do_load(int'(tbl[t].len), tbl[t].exp_n, 1'b0, 2, $sformatf("tbl%0d", t));
        end

        // Randomized loads against the model.
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(0, 31);
            do_load(len, eff_n(len), 1'b0, 3, $sformatf("rand%0d", r));
        end

        // Abort: reset asserted mid-cycle after 6 bytes of a 4-word load.
        load_start = 1'b1;
        load_len   = 5'd4;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'(8'h40 + i);
            step();
        end
        byte_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ready", 32'(byte_ready), 32'd0);
        chk("abort cpu_rst", 32'(cpu_rst), 32'd1);
        chk("abort done", 32'(load_done), 32'd0);
        model_reset();
        step();
        rst = 1'b0;
        step();
        chk("abort idle cpu_rst", 32'(cpu_rst), 32'd1);
        run = 1'b1;
        step();
        run = 1'b0;
        chk("abort run cpu_rst", 32'(cpu_rst), 32'd0);
        check_mem("abort mem");
        step();
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(1, 1, 1'b0, 0, "after_abort");
        fetch_addr = 32'd0; #1; chk("after_abort w0", fetch_data, 32'h44332211);
        step();

        // Priority: load_start beats run in IDLE.
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        step();
        do_load(3, 3, 1'b1, 1, "priority");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Controller for the CPU's instruction memory. It owns a writable SIZE-word instruction store and loads programs into it from a byte stream using a valid/ready handshake. It holds the schoolRISCV CPU in reset while a program is loading, then releases it. It serves the CPU's combinational instruction-fetch port once the program is running.

## Interface

Parameters:

- SIZE, 16, number of 32-bit instruction words; power of two, at least 2.
- ADDR_W, $clog2(SIZE), word-index width. Derived; do not override.

Ports:

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  IDLE-only request to release the CPU with the current memory contents.
- load_start  in  1  request to begin loading a program; sampled in IDLE or RUN.
- load_len  in  ADDR_W+1  number of words to load, sampled with load_start; 0 or any value above SIZE means SIZE.
- byte_data  in  8  program byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  the loader accepts a byte this cycle.
- load_done  out  1  one-cycle pulse when the last word has been written.
- busy  out  1  high while in LOAD.
- cpu_rst  out  1  reset to the CPU; high in IDLE and LOAD, low in RUN.
- fetch_addr  in  32  instruction word index from the CPU; only bits [ADDR_W-1:0] are used.
- fetch_data  out  32  instruction returned to the CPU.

## Operation

- Storage: SIZE x 32 flops. rst sets every word to 32'h00000013 (nop).
- States: IDLE, LOAD, RUN. Reset state is IDLE.
- IDLE:
  - load_start → LOAD.
  - else run → RUN.
  - If both are high, load_start wins.
- LOAD:
  - Entry clears the byte counter (2 bits), the word address (ADDR_W bits) and the assembly register.
  - Latches the effective length N, where N = load_len if 1 ≤ load_len ≤ SIZE, otherwise SIZE.
- Byte acceptance: byte_ready = (state == LOAD). A byte is accepted when byte_valid && byte_ready.
- Word assembly is little-endian:
  - Byte k (k = 0..3) of a word goes to bits [8k+7:8k].
  - On the 4th accepted byte, the full word is written to mem[waddr] at that edge, then waddr increments and the byte counter wraps to 0.
- LOAD exit: when the written word is word N-1, the state goes to RUN at the same edge. The load_done register is set for the next cycle only.
- Ignored inputs:
  - load_start during LOAD.
  - run outside IDLE.
  - byte_valid outside LOAD.
- RUN:
  - load_start → LOAD; the CPU is re-held in reset for the whole load.
  - No other exit except rst.
- Fetch port: fetch_data = mem[fetch_addr[ADDR_W-1:0]] in RUN. In IDLE and LOAD it returns 32'h00000013.
- Upper fetch_addr bits are ignored, so addresses wrap modulo SIZE.
- Words at index ≥ N keep their previous contents after a load.

## Timing

- Reset values: byte_ready=0, load_done=0, busy=0, cpu_rst=1, fetch_data=32'h00000013.
- byte_ready, busy and cpu_rst are decoded from the state register. They change one cycle after the triggering input is sampled.
- Load throughput: at most one byte per cycle. Gaps in byte_valid stall the load without losing data.
- Minimum load time is 4N cycles of accepted bytes. The cycle after the last byte:
  - state=RUN
  - cpu_rst=0
  - load_done=1
  - byte_ready=0
- Write visibility: a word written at edge t is visible on fetch_data from cycle t+1 when in RUN.
- fetch_data is combinational from fetch_addr, with zero cycles of latency.
- Reset mid-load: asynchronous return to IDLE. Memory goes back to nop, counters clear, and any partial word is discarded. The next load starts at word 0, byte 0.

## Test plan

- **Reset:** assert rst mid-cycle → outputs immediately equal the reset values; fetch_data=32'h00000013 for any address.
- **2-word load, no gaps:**
  - Stimulus: load_start with load_len=2, then bytes 93 02 30 12 37 53 34 12 on consecutive cycles.
  - Response: mem[0]=32'h12300293, mem[1]=32'h12345337; load_done high for exactly one cycle after the 8th byte; cpu_rst low in that same cycle; fetch_addr=1 → 32'h12345337; mem[2] still nop.
- **Backpressure:** same load as the 2-word case with random 0–3 cycle gaps in byte_valid → identical memory contents; byte_ready stays high until the final byte.
- **Full load:** load_len=0 and 64 bytes (word i = 32'h00000100*i + 32'h13) → all 16 words written; fetch_addr=17 returns word 1.
- **Reload during RUN:**
  - Stimulus: in RUN, pulse load_start with load_len=1 and send bytes ef be ad de.
  - Response: cpu_rst high for the entire load; mem[0]=32'hdeadbeef; other words unchanged; return to RUN.
- **Abort and priority:**
  - Stimulus 1: rst after 6 bytes of a 4-word load. Response: IDLE, all words nop.
  - Stimulus 2: run and load_start high together in IDLE. Response: LOAD entered.
